// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a single-cycle word-wide data memory.
// Define LSU_SUBWORD_EN to enable byte/halfword accesses (read-modify-write for sub-word stores).
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqData,
    output logic        ready,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        misaligned,
    output logic [31:0] memAddress,
    output logic        memWriteEnable,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] STORE     = 3'd2;
`ifdef LSU_SUBWORD_EN
    localparam logic [2:0] RMW_READ  = 3'd3;
    localparam logic [2:0] RMW_WRITE = 3'd4;
`endif
    localparam logic [2:0] DONE      = 3'd5;

    logic [2:0]  state, state_nxt;
    logic        accept;
    logic        req_err;

    logic [1:0]  size_p0;
    logic        signed_p0;
    logic [31:0] addr_p0;
    logic [31:0] data_p0;
`ifdef LSU_SUBWORD_EN
    logic [31:0] rmw_p1;
`endif

    function automatic logic access_error(input logic [1:0] size, input logic [1:0] lane);
`ifdef LSU_SUBWORD_EN
        return (size == 2'b11) || (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
`else
        return (size != 2'b10) || (lane != 2'b00);
`endif
    endfunction

    // Lane extraction plus sign/zero extension of a loaded word.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] bs;
        logic signed [31:0] hs;
        logic [31:0]        r;
        b  = word[{lane, 3'b000} +: 8];
        h  = word[{lane[1], 4'b0000} +: 16];
        bs = b;
        hs = h;
        case (size)
            2'b00:   r = sgn ? bs : {24'd0, b};
            2'b01:   r = sgn ? hs : {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef LSU_SUBWORD_EN
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] m;
        m = word;
        if (size == 2'b00)
            m[{lane, 3'b000} +: 8] = data[7:0];
        else
            m[{lane[1], 4'b0000} +: 16] = data[15:0];
        return m;
    endfunction
`endif

    assign ready     = (state == IDLE);
    assign respValid = (state == DONE);
    assign accept    = req && ready;
    assign req_err   = access_error(reqSize, reqAddr[1:0]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nxt = DONE;
                    else if (!reqWrite)
                        state_nxt = LOAD;
`ifdef LSU_SUBWORD_EN
                    else if (reqSize != 2'b10)
                        state_nxt = RMW_READ;
`endif
                    else
                        state_nxt = STORE;
                end
            end
            LOAD:      state_nxt = DONE;
            STORE:     state_nxt = DONE;
`ifdef LSU_SUBWORD_EN
            RMW_READ:  state_nxt = RMW_WRITE;
            RMW_WRITE: state_nxt = DONE;
`endif
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Request capture stage (p0) and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            respData   <= 32'd0;
            misaligned <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                respData   <= 32'd0;
                misaligned <= req_err;
            end else if (state == LOAD) begin
                respData <= load_extend(memDataOut, size_p0, addr_p0[1:0], signed_p0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            size_p0   <= reqSize;
            signed_p0 <= reqSigned;
            addr_p0   <= reqAddr;
            data_p0   <= reqData;
        end
`ifdef LSU_SUBWORD_EN
        // Read word of the read-modify-write (p1)
        if (state == RMW_READ)
            rmw_p1 <= memDataOut;
`endif
    end

    // Memory-side outputs decode straight from state, so reset silences them at once.
    always_comb begin
        memAddress     = 32'd0;
        memWriteEnable = 1'b0;
        memDataIn      = 32'd0;
        case (state)
            LOAD: begin
                memAddress = {addr_p0[31:2], 2'b00};
            end
            STORE: begin
                memAddress     = {addr_p0[31:2], 2'b00};
                memWriteEnable = 1'b1;
                memDataIn      = data_p0;
            end
`ifdef LSU_SUBWORD_EN
            RMW_READ: begin
                memAddress = {addr_p0[31:2], 2'b00};
            end
            RMW_WRITE: begin
                memAddress     = {addr_p0[31:2], 2'b00};
                memWriteEnable = 1'b1;
                memDataIn      = store_merge(rmw_p1, data_p0, size_p0, addr_p0[1:0]);
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; expectations adapt to whether LSU_SUBWORD_EN is defined.
module tb_load_store_unit;

`ifdef LSU_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic        ready;
    logic        respValid;
    logic [31:0] respData;
    logic        misaligned;
    logic [31:0] memAddress;
    logic        memWriteEnable;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;

    logic [31:0] mem [16];
    int          n_writes;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int n_checks;
    int n_fail;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .reqWrite       (reqWrite),
        .reqSize        (reqSize),
        .reqSigned      (reqSigned),
        .reqAddr        (reqAddr),
        .reqData        (reqData),
        .ready          (ready),
        .respValid      (respValid),
        .respData       (respData),
        .misaligned     (misaligned),
        .memAddress     (memAddress),
        .memWriteEnable (memWriteEnable),
        .memDataIn      (memDataIn),
        .memDataOut     (memDataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memDataOut = mem[memAddress[5:2]];

    initial n_writes = 0;
    always @(posedge clk) begin
        if (memWriteEnable) begin
            n_writes <= n_writes + 1;
            wr_addr  <= memAddress;
            wr_data  <= memDataIn;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        int          exp_lat;
        logic [31:0] exp_wword;
        int          exp_writes;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic mis);
        int w;
        w = 0;
        @(negedge clk);
        while (!ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        req       = 1'b1;
        reqWrite  = wr;
        reqSize   = sz;
        reqSigned = sg;
        reqAddr   = a;
        reqData   = d;
        lat = 0;
        rd  = 32'd0;
        mis = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) req = 1'b0;
        end while (!respValid && lat < 8);
        if (respValid) begin
            rd  = respData;
            mis = misaligned;
        end else begin
            lat = -1;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        mis;
        int          w0;
        bit          seen;
        vec_t        v;

        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;

        //            wr    size   sgn   addr    data          init          exp_rdata     mis  lat wword         writes
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h11223344, 32'h11223344, 1'b0, 2, 32'h0,        0};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h81223344, 32'hFFFFFF81, 1'b0, 2, 32'h0,        0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h81223344, 32'h00000081, 1'b0, 2, 32'h0,        0};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'hAB,       32'h11223344, 32'h0,        1'b0, 3, 32'h1122AB44, 1};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h12, 32'h0,        32'h11223344, 32'h0,        1'b1, 1, 32'h0,        0};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h11228344, 32'hFFFF8344, 1'b0, 2, 32'h0,        0};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h9ABC1234, 32'h00009ABC, 1'b0, 2, 32'h0,        0};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h16, 32'hDEADBEEF, 32'h11223344, 32'h0,        1'b0, 3, 32'hBEEF3344, 1};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 2, 32'hCAFEF00D, 1};
        vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        32'h12345678, 32'h0,        1'b1, 1, 32'h0,        0};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h11, 32'h5555,     32'h11223344, 32'h0,        1'b1, 1, 32'h0,        0};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h21, 32'h77777777, 32'h0,        32'h0,        1'b1, 1, 32'h0,        0};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h0E, 32'h0,        32'h00800000, 32'hFFFFFF80, 1'b0, 2, 32'h0,        0};
        vecs[13] = '{1'b1, 2'b00, 1'b0, 32'h0B, 32'h12345633, 32'hFFFFFFFF, 32'h0,        1'b0, 3, 32'h33FFFFFF, 1};
        vecs[14] = '{1'b0, 2'b10, 1'b1, 32'h3C, 32'h0,        32'h80000001, 32'h80000001, 1'b0, 2, 32'h0,        0};

        rst_n     = 1'b0;
        req       = 1'b0;
        reqWrite  = 1'b0;
        reqSize   = 2'b10;
        reqSigned = 1'b0;
        reqAddr   = 32'd0;
        reqData   = 32'd0;

        #3;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_respValid", {31'd0, respValid}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        check("rst_memWriteEnable", {31'd0, memWriteEnable}, 32'd0);
        check("rst_respData", respData, 32'd0);
        check("rst_memAddress", memAddress, 32'd0);
        check("rst_memDataIn", memDataIn, 32'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            v = vecs[i];
            if (!SUB && v.size != 2'b10) begin
                v.exp_rdata  = 32'd0;
                v.exp_mis    = 1'b1;
                v.exp_lat    = 1;
                v.exp_writes = 0;
            end
            mem[v.addr[5:2]] = v.init;
            w0 = n_writes;
            do_req(v.wr, v.size, v.sgn, v.addr, v.data, lat, rd, mis);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
            check($sformatf("v%0d_misaligned", i), {31'd0, mis}, {31'd0, v.exp_mis});
            check($sformatf("v%0d_respData", i), rd, v.exp_rdata);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_write_count", i), 32'(n_writes - w0), 32'(v.exp_writes));
            if (v.exp_writes > 0) begin
                check($sformatf("v%0d_write_data", i), wr_data, v.exp_wword);
                check($sformatf("v%0d_write_addr", i), wr_addr, {v.addr[31:2], 2'b00});
            end
            check($sformatf("v%0d_pulse_end", i), {30'd0, respValid, ready}, 32'd1);
            check($sformatf("v%0d_idle_addr", i), memAddress, 32'd0);
        end

        // Reset in the middle of a store: halfword RMW when sub-word is built in, word store otherwise.
        mem[5] = 32'h11223344;
        w0 = n_writes;
        @(negedge clk);
        req       = 1'b1;
        reqWrite  = 1'b1;
        reqSize   = SUB ? 2'b01 : 2'b10;
        reqSigned = 1'b0;
        reqAddr   = 32'h16;
        reqData   = 32'h00005555;
        @(posedge clk);
        #1;
        req   = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_memWriteEnable", {31'd0, memWriteEnable}, 32'd0);
        check("midrst_respValid", {31'd0, respValid}, 32'd0);
        check("midrst_memAddress", memAddress, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (respValid) seen = 1'b1;
        end
        check("midrst_no_resp", {31'd0, seen}, 32'd0);
        check("midrst_no_write", 32'(n_writes - w0), 32'd0);

        w0 = n_writes;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0BADCAFE, lat, rd, mis);
        check("after_rst_latency", 32'(lat), 32'd2);
        check("after_rst_misaligned", {31'd0, mis}, 32'd0);
        @(posedge clk);
        #1;
        check("after_rst_write_count", 32'(n_writes - w0), 32'd1);
        check("after_rst_write_data", wr_data, 32'h0BADCAFE);

        // A request raised during DONE must wait for the following IDLE cycle.
        mem[4] = 32'h11223344;
        mem[5] = 32'hA5A5A5A5;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, mis);
        check("done_first_respData", rd, 32'h11223344);
        req       = 1'b1;
        reqWrite  = 1'b0;
        reqSize   = 2'b10;
        reqSigned = 1'b0;
        reqAddr   = 32'h14;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) check("done_not_accepted", {31'd0, ready}, 32'd1);
            if (lat == 2) req = 1'b0;
        end while (!respValid && lat < 8);
        req = 1'b0;
        check("done_second_latency", 32'(lat), 32'd3);
        check("done_second_respData", respData, 32'hA5A5A5A5);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  1  CPU access request; held by CPU until accepted.
REQ-005 reqWrite  input  1  1 = store, 0 = load.
REQ-006 reqSize  input  2  00 = byte, 01 = halfword, 10 = word, 11 = invalid.
REQ-007 reqSigned  input  1  sign-extend loaded byte or halfword when 1; zero-extend when 0.
REQ-008 reqAddr  input  32  byte address.
REQ-009 reqData  input  32  store data, right-justified.
REQ-010 ready  output  1  high exactly when state is IDLE.
REQ-011 respValid  output  1  one-cycle completion pulse.
REQ-012 respData  output  32  extended load result; 0 for stores and errors.
REQ-013 misaligned  output  1  error flag, valid only with respValid.
REQ-014 memAddress  output  32  word address to data memory, {addr[31:2],2'b00}.
REQ-015 memWriteEnable  output  1  data-memory write strobe.
REQ-016 memDataIn  output  32  write word to data memory.
REQ-017 memDataOut  input  32  combinational read word from data memory.

Function
REQ-018 A request SHALL be accepted at a rising edge where req and ready are both 1; the block SHALL register reqWrite, reqSize, reqSigned, reqAddr and reqData at acceptance, and SHALL ignore req while ready is 0.
REQ-019 States SHALL be IDLE, LOAD, STORE, RMW_READ, RMW_WRITE and DONE.
REQ-020 Transitions from IDLE on acceptance SHALL be: error -> DONE; load -> LOAD; word store -> STORE; byte or halfword store -> RMW_READ.
REQ-021 Remaining transitions SHALL be: LOAD -> DONE; STORE -> DONE; RMW_READ -> RMW_WRITE; RMW_WRITE -> DONE; DONE -> IDLE.
REQ-022 respValid SHALL be 1 only in DONE; respData and misaligned are registered and held stable during DONE.
REQ-023 Latency from the acceptance edge to respValid SHALL be: 1 cycle for an error; 2 cycles for a load or a word store; 3 cycles for a byte or halfword store.
REQ-024 memAddress SHALL be driven from the registered address in LOAD, STORE, RMW_READ and RMW_WRITE, and SHALL be 0 in all other states.
REQ-025 memWriteEnable SHALL be 1 only in STORE and RMW_WRITE.
REQ-026 memDataIn SHALL be 0 in all states other than STORE and RMW_WRITE.
REQ-027 Byte lanes SHALL be little-endian: a byte at lane k = addr[1:0] occupies bits [8k+7:8k]; a halfword at addr[1] occupies bits [16*addr[1]+15 : 16*addr[1]].
REQ-028 In LOAD, the lane selected by the registered address SHALL be extracted from memDataOut, extended per reqSigned, and captured into respData.
REQ-029 In RMW_READ, memDataOut SHALL be captured; RMW_WRITE SHALL drive that captured word with only the target lane replaced by the low byte or halfword of reqData.
REQ-030 An error SHALL be any of: reqSize = 11; a halfword with addr[0] = 1; a word with addr[1:0] != 0.
REQ-031 An error SHALL produce misaligned = 1 and respData = 0 in DONE, with no memory access and no memWriteEnable.
REQ-032 A request presented in the DONE cycle SHALL NOT be accepted; the earliest acceptance is the following IDLE cycle.

Reset
REQ-033 Assertion of rst_n = 0 SHALL immediately force state IDLE, ready = 1, and respValid, misaligned, memWriteEnable = 0; respData, memAddress and memDataIn SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL drop the pending request with no response, and SHALL deassert memWriteEnable before the next edge so no write occurs.

Configuration
REQ-035 When macro LSU_SUBWORD_EN is defined, byte and halfword accesses SHALL operate as specified above.
REQ-036 When LSU_SUBWORD_EN is undefined, reqSize 00 and 01 SHALL be treated as errors; RMW_READ and RMW_WRITE SHALL be absent and word accesses SHALL be unchanged.

Verification
REQ-037 Word load at 0x10 with memory word 0x11223344 -> respValid 2 cycles after acceptance, respData = 0x11223344, misaligned = 0.
REQ-038 Signed byte load at 0x13 with memory 0x81223344 -> respData = 0xFFFFFF81; the same load unsigned -> 0x00000081.
REQ-039 Byte store of 0xAB to 0x11 with memory 0x11223344 -> one write of 0x1122AB44 to memAddress 0x10, respValid 3 cycles after acceptance.
REQ-040 Word load at 0x12 -> respValid 1 cycle after acceptance, misaligned = 1, respData = 0, memWriteEnable never asserted.
REQ-041 rst_n pulsed low during RMW_READ of a halfword store -> no write occurs, no respValid, ready = 1 immediately; the next request completes normally.
REQ-042 Build without LSU_SUBWORD_EN, halfword load at 0x10 -> misaligned = 1 after 1 cycle.
